// File: rtl/if_id_hazard_stage.sv
// ============================================================================
// if_id_hazard_stage: IF/ID pipeline register with load-use stall and
// EX-redirect flush control, plus saturating stall/flush event counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module if_id_hazard_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      instru_in,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             branch_taken,
    input  logic             jump_taken,
    output logic [31:0]      pc_out,
    output logic [31:0]      instru_out,
    output logic             valid_out,
    output logic             pc_write,
    output logic             ID_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       load_use;
    logic       redirect;

    assign opcode = instru_out[6:0];
    assign rs1    = instru_out[19:15];
    assign rs2    = instru_out[24:20];

    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        if (opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL)
            uses_rs1 = 1'b0;
        if (opcode == OP_RTYPE || opcode == OP_STORE || opcode == OP_BRANCH)
            uses_rs2 = 1'b1;
    end

    // Invalid slots hold an injected NOP and must never stall on stale fields.
    assign load_use = valid_out && ex_mem_read && (ex_rd != 5'd0) &&
                      ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
    assign redirect = branch_taken || jump_taken;

    always_comb begin
        ID_flush = 1'b0;
        pc_write = 1'b1;
        if (redirect) begin
            ID_flush = 1'b1;
            pc_write = 1'b1;
        end else if (load_use) begin
            ID_flush = 1'b1;
            pc_write = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_out      <= 32'd0;
            instru_out  <= NOP_INSTR;
            valid_out   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (redirect) begin
            pc_out     <= 32'd0;
            instru_out <= NOP_INSTR;
            valid_out  <= 1'b0;
            if (flush_count != {CNT_W{1'b1}})
                flush_count <= flush_count + 1'b1;
        end else if (load_use) begin
            if (stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + 1'b1;
        end else begin
            pc_out     <= pc_in;
            instru_out <= instru_in;
            valid_out  <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_id_hazard_stage.sv
// ============================================================================
// tb_if_id_hazard_stage: directed vectors with a queue-based scoreboard.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_id_hazard_stage;

    localparam int CW = 2;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADD1 = 32'h0020_81B3; // add x3,x1,x2
    localparam logic [31:0] ADD2 = 32'h0062_02B3; // add x5,x4,x6
    localparam logic [31:0] LUI6 = 32'h0003_3337; // lui x6,0x33 (rs1 field = 6)
    localparam logic [31:0] ADDI = 32'h0050_0093; // addi x1,x0,5 (rs2 field = 5)
    localparam logic [31:0] SW78 = 32'h0074_2023; // sw x7,0(x8)

    logic          clock;
    logic          reset_n;
    logic [31:0]   pc_in;
    logic [31:0]   instru_in;
    logic          ex_mem_read;
    logic [4:0]    ex_rd;
    logic          branch_taken;
    logic          jump_taken;
    logic [31:0]   pc_out;
    logic [31:0]   instru_out;
    logic          valid_out;
    logic          pc_write;
    logic          ID_flush;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        mr;
        logic [4:0]  rd;
        logic        br;
        logic        jp;
        logic        e_flush;
        logic        e_pcw;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_valid;
        logic [1:0]  e_st;
        logic [1:0]  e_fc;
    } vec_t;

    vec_t sb_q[$];

    if_id_hazard_stage #(.NOP_INSTR(NOP), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pc_in        (pc_in),
        .instru_in    (instru_in),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .branch_taken (branch_taken),
        .jump_taken   (jump_taken),
        .pc_out       (pc_out),
        .instru_out   (instru_out),
        .valid_out    (valid_out),
        .pc_write     (pc_write),
        .ID_flush     (ID_flush),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"},     pc_out, 32'd0);
        chk({tag, "_ins"},    instru_out, NOP);
        chk({tag, "_valid"},  {31'd0, valid_out}, 32'd0);
        chk({tag, "_stall"},  {30'd0, stall_count}, 32'd0);
        chk({tag, "_flushc"}, {30'd0, flush_count}, 32'd0);
        chk({tag, "_idfl"},   {31'd0, ID_flush}, 32'd0);
        chk({tag, "_pcw"},    {31'd0, pc_write}, 32'd1);
    endtask

    // Asserts reset between clock edges and checks the state before any edge.
    task automatic pulse_reset(input string tag);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1 check_reset_state({tag, "_async"});
        @(posedge clock);
        #1 check_reset_state({tag, "_held"});
        #1 reset_n = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        pc_in        = v.pc;
        instru_in    = v.ins;
        ex_mem_read  = v.mr;
        ex_rd        = v.rd;
        branch_taken = v.br;
        jump_taken   = v.jp;
        sb_q.push_back(v);
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] ins,
                                input logic mr, input logic [4:0] rd,
                                input logic br, input logic jp,
                                input logic ef, input logic ep,
                                input logic [31:0] epc, input logic [31:0] eins,
                                input logic ev, input logic [1:0] est,
                                input logic [1:0] efc);
        vec_t v;
        v.pc = pc; v.ins = ins; v.mr = mr; v.rd = rd; v.br = br; v.jp = jp;
        v.e_flush = ef; v.e_pcw = ep; v.e_pc = epc; v.e_ins = eins;
        v.e_valid = ev; v.e_st = est; v.e_fc = efc;
        return v;
    endfunction

    // Monitor: combinational outputs mid-low-phase, registered ones after the edge.
    initial begin : monitor
        vec_t e;
        forever begin
            @(negedge clock);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("id_flush", {31'd0, ID_flush}, {31'd0, e.e_flush});
                chk("pc_write", {31'd0, pc_write}, {31'd0, e.e_pcw});
                @(posedge clock);
                #1;
                chk("pc_out",      pc_out, e.e_pc);
                chk("instru_out",  instru_out, e.e_ins);
                chk("valid_out",   {31'd0, valid_out}, {31'd0, e.e_valid});
                chk("stall_count", {30'd0, stall_count}, {30'd0, e.e_st});
                chk("flush_count", {30'd0, flush_count}, {30'd0, e.e_fc});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset_n = 1'b0;
        pc_in = 32'd0; instru_in = NOP; ex_mem_read = 1'b0; ex_rd = 5'd0;
        branch_taken = 1'b0; jump_taken = 1'b0;
        pulse_reset("rst0");

        //        pc_in   instr mr rd  br jp  fl pcw pc_out  instr_out v st fc
        apply(mk(32'h00, ADD1, 0, 0,  0, 0,  0, 1, 32'h00, ADD1, 1, 0, 0));
        apply(mk(32'h04, ADD1, 0, 0,  0, 0,  0, 1, 32'h04, ADD1, 1, 0, 0));
        apply(mk(32'h08, ADD1, 0, 0,  0, 0,  0, 1, 32'h08, ADD1, 1, 0, 0));
        apply(mk(32'h0C, ADD2, 0, 0,  0, 0,  0, 1, 32'h0C, ADD2, 1, 0, 0));
        // rs1 load-use on add x5,x4,x6
        apply(mk(32'h10, LUI6, 1, 4,  0, 0,  1, 0, 32'h0C, ADD2, 1, 1, 0));
        apply(mk(32'h10, LUI6, 0, 0,  0, 0,  0, 1, 32'h10, LUI6, 1, 1, 0));
        // lui rs1 field matches ex_rd but is not a source
        apply(mk(32'h14, ADDI, 1, 6,  0, 0,  0, 1, 32'h14, ADDI, 1, 1, 0));
        // ex_rd=0 with rs1=x0
        apply(mk(32'h18, ADD2, 1, 0,  0, 0,  0, 1, 32'h18, ADD2, 1, 1, 0));
        // rs2 load-use on add
        apply(mk(32'h1C, SW78, 1, 6,  0, 0,  1, 0, 32'h18, ADD2, 1, 2, 0));
        apply(mk(32'h1C, SW78, 0, 0,  0, 0,  0, 1, 32'h1C, SW78, 1, 2, 0));
        // taken branch with sw held
        apply(mk(32'h20, ADDI, 1, 9,  1, 0,  1, 1, 32'h00, NOP,  0, 2, 1));
        apply(mk(32'h30, ADDI, 0, 0,  0, 0,  0, 1, 32'h30, ADDI, 1, 2, 1));
        // I-type: rs2 field matches but is not a source
        apply(mk(32'h34, ADD1, 1, 5,  0, 0,  0, 1, 32'h34, ADD1, 1, 2, 1));
        // jump and load-use together: flush wins
        apply(mk(32'h38, ADD2, 1, 1,  0, 1,  1, 1, 32'h00, NOP,  0, 2, 2));
        // back-to-back redirects, flush_count saturates at 3
        apply(mk(32'h40, ADD2, 0, 0,  1, 0,  1, 1, 32'h00, NOP,  0, 2, 3));
        apply(mk(32'h44, ADD2, 0, 0,  0, 1,  1, 1, 32'h00, NOP,  0, 2, 3));
        apply(mk(32'h48, ADD2, 0, 0,  0, 0,  0, 1, 32'h48, ADD2, 1, 2, 3));
        @(negedge clock);
        pulse_reset("rst1");

        apply(mk(32'h50, ADD2, 0, 0,  0, 0,  0, 1, 32'h50, ADD2, 1, 0, 0));
        // five forced stalls: stall_count 1,2,3,3,3
        apply(mk(32'h54, ADD1, 1, 4,  0, 0,  1, 0, 32'h50, ADD2, 1, 1, 0));
        apply(mk(32'h54, ADD1, 1, 4,  0, 0,  1, 0, 32'h50, ADD2, 1, 2, 0));
        apply(mk(32'h54, ADD1, 1, 4,  0, 0,  1, 0, 32'h50, ADD2, 1, 3, 0));
        apply(mk(32'h54, ADD1, 1, 4,  0, 0,  1, 0, 32'h50, ADD2, 1, 3, 0));
        apply(mk(32'h54, ADD1, 1, 4,  0, 0,  1, 0, 32'h50, ADD2, 1, 3, 0));
        @(negedge clock);
        // reset mid-stall, hazard inputs still asserted
        pulse_reset("rst2");
        apply(mk(32'h58, ADD1, 1, 4,  0, 0,  0, 1, 32'h58, ADD1, 1, 0, 0));
        apply(mk(32'h5C, ADD2, 1, 1,  0, 0,  1, 0, 32'h58, ADD1, 1, 1, 0));

        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
